// File: rtl/spu_pkg.sv
// spu_pkg: shared SPU register-file types and sizes
//   qword_t    128-bit register value, bit 0 = MSB
//   reg_addr_t 7-bit register address
//   fwd_tap_t  one in-flight staged result (data, destination, reg_write flag)
package spu_pkg;
  localparam int NUM_REGS = 128;
  localparam int FWD_TAPS = 4;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  typedef logic [0:DATA_W-1] qword_t;
  typedef logic [0:ADDR_W-1] reg_addr_t;
  typedef struct packed {
    qword_t    data;
    reg_addr_t addr;
    logic      valid;
  } fwd_tap_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority operand resolution for one source operand
//   addr_i                    operand address
//   even_taps_i / odd_taps_i  staged results, index 0 = youngest
//   wb_even_* / wb_odd_*      same-cycle writeback ports
//   arr_word_i                array contents at addr_i
//   data_o                    resolved operand value
module fwd_select
  import spu_pkg::*;
(
  input  reg_addr_t                  addr_i,
  input  fwd_tap_t [FWD_TAPS-1:0]    even_taps_i,
  input  fwd_tap_t [FWD_TAPS-1:0]    odd_taps_i,
  input  logic                       wb_even_en_i,
  input  reg_addr_t                  wb_even_addr_i,
  input  qword_t                     wb_even_data_i,
  input  logic                       wb_odd_en_i,
  input  reg_addr_t                  wb_odd_addr_i,
  input  qword_t                     wb_odd_data_i,
  input  qword_t                     arr_word_i,
  output qword_t                     data_o
);
  // Lowest priority is assigned first so later, higher-priority matches override it.
  always_comb begin
    data_o = arr_word_i;
    if (wb_even_en_i && wb_even_addr_i == addr_i) data_o = wb_even_data_i;
    if (wb_odd_en_i && wb_odd_addr_i == addr_i) data_o = wb_odd_data_i;
    for (int k = FWD_TAPS - 1; k >= 0; k--) begin
      if (odd_taps_i[k].valid && odd_taps_i[k].addr == addr_i) data_o = odd_taps_i[k].data;
      if (even_taps_i[k].valid && even_taps_i[k].addr == addr_i) data_o = even_taps_i[k].data;
    end
  end
endmodule

// File: rtl/register_file_fwd.sv
// register_file_fwd: 128x128 SPU register file with operand forwarding
//   clk, reset            clock, synchronous active-high reset
//   rd_en, r[abc]_addr    operand capture request and source addresses
//   wb_even_*, wb_odd_*   writeback ports (odd wins on same address)
//   fwd_even_*, fwd_odd_* packed staging taps, tap k at [k*W +: W]
//   ra, rb, rc            registered resolved operands
//   operands_valid        operands captured on the last edge
module register_file_fwd
  import spu_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rd_en,
  input  reg_addr_t                    ra_addr,
  input  reg_addr_t                    rb_addr,
  input  reg_addr_t                    rc_addr,
  input  qword_t                       wb_even_data,
  input  reg_addr_t                    wb_even_addr,
  input  logic                         wb_even_en,
  input  qword_t                       wb_odd_data,
  input  reg_addr_t                    wb_odd_addr,
  input  logic                         wb_odd_en,
  input  logic [FWD_TAPS*DATA_W-1:0]   fwd_even_data,
  input  logic [FWD_TAPS*ADDR_W-1:0]   fwd_even_addr,
  input  logic [FWD_TAPS-1:0]          fwd_even_valid,
  input  logic [FWD_TAPS*DATA_W-1:0]   fwd_odd_data,
  input  logic [FWD_TAPS*ADDR_W-1:0]   fwd_odd_addr,
  input  logic [FWD_TAPS-1:0]          fwd_odd_valid,
  output qword_t                       ra,
  output qword_t                       rb,
  output qword_t                       rc,
  output logic                         operands_valid
);
  qword_t                  mem_q [NUM_REGS];
  qword_t                  opnd_q [3];
  qword_t                  opnd_d [3];
  reg_addr_t               rd_addr [3];
  logic                    valid_q;
  fwd_tap_t [FWD_TAPS-1:0] ev_taps;
  fwd_tap_t [FWD_TAPS-1:0] od_taps;
  assign rd_addr = '{ra_addr, rb_addr, rc_addr};
  always_comb begin
    for (int k = 0; k < FWD_TAPS; k++) begin
      ev_taps[k] = '{data: fwd_even_data[k*DATA_W +: DATA_W], addr: fwd_even_addr[k*ADDR_W +: ADDR_W], valid: fwd_even_valid[k]};
      od_taps[k] = '{data: fwd_odd_data[k*DATA_W +: DATA_W], addr: fwd_odd_addr[k*ADDR_W +: ADDR_W], valid: fwd_odd_valid[k]};
    end
  end
  for (genvar g = 0; g < 3; g++) begin : g_sel
    fwd_select u_sel (
      .addr_i         (rd_addr[g]),
      .even_taps_i    (ev_taps),
      .odd_taps_i     (od_taps),
      .wb_even_en_i   (wb_even_en),
      .wb_even_addr_i (wb_even_addr),
      .wb_even_data_i (wb_even_data),
      .wb_odd_en_i    (wb_odd_en),
      .wb_odd_addr_i  (wb_odd_addr),
      .wb_odd_data_i  (wb_odd_data),
      .arr_word_i     (mem_q[rd_addr[g]]),
      .data_o         (opnd_d[g])
    );
  end
  // Odd write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      if (wb_even_en) mem_q[wb_even_addr] <= wb_even_data;
      if (wb_odd_en) mem_q[wb_odd_addr] <= wb_odd_data;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) opnd_q[i] <= '0;
      valid_q <= 1'b0;
    end else begin
      if (rd_en) opnd_q <= opnd_d;
      valid_q <= rd_en;
    end
  end
  assign ra = opnd_q[0];
  assign rb = opnd_q[1];
  assign rc = opnd_q[2];
  assign operands_valid = valid_q;
endmodule

// File: tb/tb_register_file_fwd.sv
// tb_register_file_fwd: random + directed check of register_file_fwd against a behavioural model
module tb_register_file_fwd;
  logic         clk = 1'b0;
  logic         reset, rd_en;
  logic [6:0]   ra_addr, rb_addr, rc_addr, wb_even_addr, wb_odd_addr;
  logic [127:0] wb_even_data, wb_odd_data;
  logic         wb_even_en, wb_odd_en;
  logic [511:0] fwd_even_data, fwd_odd_data;
  logic [27:0]  fwd_even_addr, fwd_odd_addr;
  logic [3:0]   fwd_even_valid, fwd_odd_valid;
  logic [127:0] ra, rb, rc;
  logic         operands_valid;
  logic [127:0] m_mem [128];
  logic [127:0] e_ra, e_rb, e_rc;
  logic         e_v;
  logic         chk_on = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  register_file_fwd dut (
    .clk(clk), .reset(reset), .rd_en(rd_en),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .wb_even_data(wb_even_data), .wb_even_addr(wb_even_addr), .wb_even_en(wb_even_en),
    .wb_odd_data(wb_odd_data), .wb_odd_addr(wb_odd_addr), .wb_odd_en(wb_odd_en),
    .fwd_even_data(fwd_even_data), .fwd_even_addr(fwd_even_addr), .fwd_even_valid(fwd_even_valid),
    .fwd_odd_data(fwd_odd_data), .fwd_odd_addr(fwd_odd_addr), .fwd_odd_valid(fwd_odd_valid),
    .ra(ra), .rb(rb), .rc(rc), .operands_valid(operands_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [127:0] resolve(input logic [6:0] a);
    for (int k = 0; k < 4; k++) begin
      if (fwd_even_valid[k] && fwd_even_addr[k*7 +: 7] == a) return fwd_even_data[k*128 +: 128];
      if (fwd_odd_valid[k] && fwd_odd_addr[k*7 +: 7] == a) return fwd_odd_data[k*128 +: 128];
    end
    if (wb_odd_en && wb_odd_addr == a) return wb_odd_data;
    if (wb_even_en && wb_even_addr == a) return wb_even_data;
    return m_mem[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) m_mem[i] = '0;
      e_ra = '0; e_rb = '0; e_rc = '0; e_v = 1'b0;
    end else begin
      if (rd_en) begin
        e_ra = resolve(ra_addr); e_rb = resolve(rb_addr); e_rc = resolve(rc_addr);
      end
      e_v = rd_en;
      if (wb_even_en) m_mem[wb_even_addr] = wb_even_data;
      if (wb_odd_en) m_mem[wb_odd_addr] = wb_odd_data;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_ra", ra, e_ra);
      chk("model_rb", rb, e_rb);
      chk("model_rc", rc, e_rc);
      chk("model_valid", {127'b0, operands_valid}, {127'b0, e_v});
    end
  end

  task automatic idle();
    rd_en = 0; ra_addr = 0; rb_addr = 0; rc_addr = 0;
    wb_even_en = 0; wb_even_addr = 0; wb_even_data = '0;
    wb_odd_en = 0; wb_odd_addr = 0; wb_odd_data = '0;
    fwd_even_data = '0; fwd_even_addr = '0; fwd_even_valid = '0;
    fwd_odd_data = '0; fwd_odd_addr = '0; fwd_odd_valid = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    reset = 1; idle();
    tick();
    chk_on = 1;
    tick();
    reset = 0;
    rd_en = 1; ra_addr = 5; rb_addr = 6; rc_addr = 7;
    tick();
    chk("rst_ra", ra, '0); chk("rst_rb", rb, '0); chk("rst_rc", rc, '0);
    chk("rst_valid", {127'b0, operands_valid}, 128'd1);
    idle(); wb_even_en = 1; wb_even_addr = 3; wb_even_data = a5;
    tick();
    idle(); rd_en = 1; ra_addr = 3;
    tick();
    chk("wb_read", ra, a5);
    idle(); wb_odd_en = 1; wb_odd_addr = 9; wb_odd_data = 128'h1; rd_en = 1; ra_addr = 9;
    tick();
    chk("bypass", ra, 128'h1);
    idle(); rd_en = 1; ra_addr = 9;
    tick();
    chk("bypass_stored", ra, 128'h1);
    idle();
    fwd_even_valid[0] = 1; fwd_even_addr[6:0] = 4; fwd_even_data[127:0] = 128'h22;
    fwd_odd_valid[2] = 1; fwd_odd_addr[20:14] = 4; fwd_odd_data[383:256] = 128'h33;
    wb_even_en = 1; wb_even_addr = 4; wb_even_data = 128'h44;
    rd_en = 1; ra_addr = 4; rb_addr = 4;
    tick();
    chk("tap_prio_ra", ra, 128'h22);
    chk("tap_prio_rb", rb, 128'h22);
    idle(); fwd_even_addr[6:0] = 3; fwd_even_data[127:0] = 128'hBAD; rd_en = 1; ra_addr = 4; rb_addr = 3;
    tick();
    chk("array_after_tap", ra, 128'h44);
    chk("invalid_tap", rb, a5);
    idle(); wb_even_en = 1; wb_odd_en = 1; wb_even_addr = 10; wb_odd_addr = 10;
    wb_even_data = 128'hE; wb_odd_data = 128'hF;
    tick();
    idle(); rd_en = 1; rc_addr = 10;
    tick();
    chk("dual_wb", rc, 128'hF);
    idle();
    tick();
    chk("hold_rc", rc, 128'hF);
    chk("hold_valid", {127'b0, operands_valid}, '0);
    wb_even_en = 1; wb_even_addr = 11; wb_even_data = 128'h1234;
    tick();
    idle(); reset = 1; rd_en = 1; ra_addr = 11; wb_odd_en = 1; wb_odd_addr = 12; wb_odd_data = 128'h77;
    tick();
    chk("midrst_valid", {127'b0, operands_valid}, '0);
    chk("midrst_ra", ra, '0);
    idle(); reset = 0; rd_en = 1; ra_addr = 11; rb_addr = 12; rc_addr = 3;
    tick();
    chk("postrst_11", ra, '0); chk("postrst_12", rb, '0); chk("postrst_3", rc, '0);
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      rd_en = $urandom_range(0, 1);
      ra_addr = $urandom_range(0, 15); rb_addr = $urandom_range(0, 15); rc_addr = $urandom_range(0, 15);
      wb_even_en = $urandom_range(0, 1); wb_even_addr = $urandom_range(0, 15);
      wb_odd_en = $urandom_range(0, 1); wb_odd_addr = $urandom_range(0, 15);
      wb_even_data = {$urandom, $urandom, $urandom, $urandom};
      wb_odd_data = {$urandom, $urandom, $urandom, $urandom};
      fwd_even_valid = 4'($urandom); fwd_odd_valid = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        fwd_even_addr[k*7 +: 7] = 7'($urandom_range(0, 15));
        fwd_odd_addr[k*7 +: 7] = 7'($urandom_range(0, 15));
        fwd_even_data[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        fwd_odd_data[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    idle(); reset = 0;
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
